// File: rtl/socetlib_sync_filter.sv
// Per-channel flop synchronizer, debounce filter and registered edge pulses; free-running, no backpressure.
// Latency: STAGES+FILTER_CYCLES edges from a stable input change to sync_out; rise/fall mark its first new cycle.
module socetlib_sync_filter #(
    parameter int   WIDTH         = 1,
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 1,
    parameter logic RESET_STATE   = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    if (STAGES < 2) begin : g_stages_err
        $error("socetlib_sync_filter: STAGES must be at least 2");
    end
    if (STAGES > 3) begin : g_stages_warn
        $warning("socetlib_sync_filter: STAGES above 3 adds latency with little MTBF gain");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_filter_err
        $error("socetlib_sync_filter: FILTER_CYCLES must be in 1..65535");
    end

    // Stage 0 may be metastable; only stage 1 samples it.
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_raw;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= {WIDTH{RESET_STATE}};
        end else begin
            sync_q[0] <= async_in;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_raw = sync_q[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          out_q;
        logic          rise_q;
        logic          fall_q;
        logic          flip;

        // A flip needs FILTER_CYCLES consecutive disagreeing samples; any agreement restarts the count.
        assign flip = (sync_raw[i] != out_q) && (cnt == LAST);

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                cnt    <= '0;
                out_q  <= RESET_STATE;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= flip & sync_raw[i];
                fall_q <= flip & ~sync_raw[i];
                if (sync_raw[i] == out_q || flip) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (flip) begin
                    out_q <= sync_raw[i];
                end
            end
        end

        assign sync_out[i] = out_q;
        assign rise[i]     = rise_q;
        assign fall[i]     = fall_q;
    end

endmodule

// File: tb/tb_socetlib_sync_filter.sv
// Bench for socetlib_sync_filter: a sample-window reference model checked every cycle, plus directed literal checks.
module tb_socetlib_sync_filter;

    logic       CLK;
    logic       nRST;
    logic [3:0] ain_a, sync_a, rise_a, fall_a;
    logic       ain_b, sync_b, rise_b, fall_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    localparam int MW [2] = '{4, 1};
    localparam int MS [2] = '{2, 3};
    localparam int MF [2] = '{3, 1};

    socetlib_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_STATE(1'b1)) dut_a (
        .CLK(CLK), .nRST(nRST), .async_in(ain_a), .sync_out(sync_a), .rise(rise_a), .fall(fall_a));

    socetlib_sync_filter #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(1), .RESET_STATE(1'b1)) dut_b (
        .CLK(CLK), .nRST(nRST), .async_in(ain_b), .sync_out(sync_b), .rise(rise_b), .fall(fall_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Reference: the output flips when the last FILTER_CYCLES synchronized samples all differ from it.
    logic m_hist [2][4][8];
    logic m_out  [2][4];
    logic m_rise [2][4];
    logic m_fall [2][4];

    always @(posedge CLK or negedge nRST) begin : model
        logic b, diff;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < MW[n]; c++) begin
                if (!nRST) begin
                    for (int k = 0; k < 8; k++) m_hist[n][c][k] = 1'b1;
                    m_out[n][c]  = 1'b1;
                    m_rise[n][c] = 1'b0;
                    m_fall[n][c] = 1'b0;
                end else begin
                    b    = (n == 0) ? ain_a[c] : ain_b;
                    diff = 1'b1;
                    for (int k = MS[n] - 1; k <= MS[n] + MF[n] - 2; k++)
                        if (m_hist[n][c][k] == m_out[n][c]) diff = 1'b0;
                    m_rise[n][c] = diff & ~m_out[n][c];
                    m_fall[n][c] = diff & m_out[n][c];
                    if (diff) m_out[n][c] = ~m_out[n][c];
                    for (int k = 7; k > 0; k--) m_hist[n][c][k] = m_hist[n][c][k-1];
                    m_hist[n][c][0] = b;
                end
            end
        end
    end

    logic [3:0] prev_a;
    logic       prev_b;
    int         last_a [4];
    int         last_b;

    always @(negedge CLK) begin : compare
        logic [3:0] eo, er, ef;
        for (int c = 0; c < 4; c++) begin
            eo[c] = m_out[0][c];
            er[c] = m_rise[0][c];
            ef[c] = m_fall[0][c];
        end
        chk("a_sync_out", sync_a, eo);
        chk("a_rise", rise_a, er);
        chk("a_fall", fall_a, ef);
        chk("b_sync_out", 4'(sync_b), 4'(m_out[1][0]));
        chk("b_rise", 4'(rise_b), 4'(m_rise[1][0]));
        chk("b_fall", 4'(fall_b), 4'(m_fall[1][0]));
        chk("a_rise_and_fall", rise_a & fall_a, 4'h0);
        chk("b_rise_and_fall", 4'(rise_b & fall_b), 4'h0);
        if (!nRST) begin
            prev_a = sync_a;
            prev_b = sync_b;
            for (int c = 0; c < 4; c++) last_a[c] = -1000;
            last_b = -1000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (sync_a[c] != prev_a[c]) begin
                    tests++;
                    if (cyc - last_a[c] < MF[0]) begin
                        fails++;
                        $display("FAIL a_flip_gap ch%0d: gap %0d cycles, need >= %0d", c, cyc - last_a[c], MF[0]);
                    end
                    last_a[c] = cyc;
                end
            end
            if (sync_b != prev_b) begin
                tests++;
                if (cyc - last_b < MF[1]) begin
                    fails++;
                    $display("FAIL b_flip_gap: gap %0d cycles, need >= %0d", cyc - last_b, MF[1]);
                end
                last_b = cyc;
            end
            prev_a = sync_a;
            prev_b = sync_b;
        end
    end

    initial begin : stim
        logic [3:0] acc, rise_v;
        int t_hi, t_lo, n_r, n_f, n_rise, rise_t;
        nRST  = 1'b1;
        ain_a = 4'h0;
        ain_b = 1'b0;

        // Reset takes effect immediately, without a clock edge.
        #3 nRST = 1'b0;
        #1;
        chk("rst_sync_a", sync_a, 4'hf);
        chk("rst_rise_a", rise_a, 4'h0);
        chk("rst_fall_a", fall_a, 4'h0);
        chk("rst_sync_b", 4'(sync_b), 4'h1);
        @(negedge CLK);
        tick;
        tick;
        #2 nRST = 1'b1;

        // Input 0 vs reset state 1: ordinary change, flip on the fifth edge (4th for dut_b).
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (i == 3) chk("rel_b_hold", 4'(sync_b), 4'h1);
            if (i == 4) begin
                chk("rel_a_hold", sync_a, 4'hf);
                chk("rel_a_nofall", fall_a, 4'h0);
                chk("rel_b_flip", 4'(sync_b), 4'h0);
                chk("rel_b_fall", 4'(fall_b), 4'h1);
            end
            if (i == 5) begin
                chk("rel_a_flip", sync_a, 4'h0);
                chk("rel_a_fall", fall_a, 4'hf);
            end
            if (i == 6) chk("rel_a_fall_end", fall_a, 4'h0);
        end
        repeat (3) tick;

        // Latency on channel 1.
        ain_a = 4'b0010;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (i < 5) chk("lat_hold", sync_a, 4'h0);
            if (i == 5) begin
                chk("lat_flip", sync_a, 4'b0010);
                chk("lat_rise", rise_a, 4'b0010);
            end
            if (i == 6) begin
                chk("lat_rise_end", rise_a, 4'h0);
                chk("lat_level", sync_a, 4'b0010);
            end
        end
        ain_a = 4'h0;
        repeat (8) tick;

        // Two-period glitch on channel 2 is dropped.
        ain_a = 4'b0100;
        tick;
        tick;
        ain_a = 4'h0;
        acc = 4'h0;
        repeat (8) begin
            tick;
            acc |= sync_a | rise_a | fall_a;
        end
        chk("glitch2_dropped", acc, 4'h0);

        // Four-period pulse on channel 2 propagates, rising and falling once each.
        ain_a = 4'b0100;
        t_hi = 0; t_lo = 0; n_r = 0; n_f = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) ain_a = 4'h0;
            tick;
            n_r += int'(rise_a[2]);
            n_f += int'(fall_a[2]);
            if (sync_a[2] && t_hi == 0) t_hi = i;
            if (t_hi != 0 && !sync_a[2] && t_lo == 0) t_lo = i;
        end
        chk("pulse4_t_hi", 4'(t_hi), 4'd5);
        chk("pulse4_t_lo", 4'(t_lo), 4'd9);
        chk("pulse4_nrise", 4'(n_r), 4'd1);
        chk("pulse4_nfall", 4'(n_f), 4'd1);
        repeat (3) tick;

        // All channels toggle together; only the 4-cycle bits survive.
        ain_a = 4'hf;
        n_rise = 0; rise_v = 4'h0; rise_t = 0; acc = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) ain_a[3:2] = 2'b00;
            if (i == 5) ain_a[1:0] = 2'b00;
            tick;
            if (rise_a != 4'h0) begin
                n_rise++;
                rise_v = rise_a;
                rise_t = i;
            end
            acc[3:2] |= sync_a[3:2];
        end
        chk("simul_nrise", 4'(n_rise), 4'd1);
        chk("simul_rise_val", rise_v, 4'b0011);
        chk("simul_rise_t", 4'(rise_t), 4'd5);
        chk("simul_hi_dropped", acc, 4'h0);
        repeat (3) tick;

        // Reset one cycle before channel 3's flip is due.
        ain_a = 4'b1000;
        repeat (4) tick;
        chk("mid_before", sync_a, 4'h0);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_sync", sync_a, 4'hf);
        chk("mid_rst_rise", rise_a, 4'h0);
        chk("mid_rst_fall", fall_a, 4'h0);
        @(negedge CLK);
        tick;
        #2 nRST = 1'b1;
        acc = 4'h0;
        repeat (10) begin
            tick;
            acc[0] = acc[0] | rise_a[3] | fall_a[3] | ~sync_a[3];
        end
        chk("mid_after_quiet", acc, 4'h0);

        // Sweep instance: STAGES=3, FILTER_CYCLES=1 flips after edge e+3.
        ain_b = 1'b0;
        repeat (6) tick;
        ain_b = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            if (i < 4) chk("sweep_hold", 4'(sync_b), 4'h0);
            if (i == 4) begin
                chk("sweep_flip", 4'(sync_b), 4'h1);
                chk("sweep_rise", 4'(rise_b), 4'h1);
            end
            if (i == 5) chk("sweep_rise_end", 4'(rise_b), 4'h0);
        end

        // Random traffic; the per-cycle compare covers pulses and flip spacing.
        repeat (20000) begin
            ain_a ^= 4'($urandom) & 4'($urandom);
            ain_b ^= 1'($urandom);
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
